nrn_sched: RTL and testbench
============================

NRN_SCHED -- requirements
Module: nrn_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_NRN, 4, neurons time-multiplexed onto one nrn instance; N, 35, word width (sign-magnitude, bit N-1 = sign); Q, 32, fraction bits; TIMEOUT, 16, max cycles waiting for nrn_flag_out; CNT_W, 8, spike-counter width.
REQ-002 The block SHALL have port clock, input, 1, single clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, one-cycle request to run one timestep.
REQ-005 The block SHALL have port clr_mem, input, 1, clears membranes and counters.
REQ-006 The block SHALL have port cur_in, input, NUM_NRN*N, input currents, neuron k at [k*N +: N].
REQ-007 The block SHALL have port nrn_flag_in, output, 1, evaluate request to the neuron.
REQ-008 The block SHALL have port nrn_vmem, output, N, stored membrane of the selected neuron.
REQ-009 The block SHALL have port nrn_in, output, N, latched current of the selected neuron.
REQ-010 The block SHALL have ports nrn_out (input, N, spike, nonzero = spike), nrn_mem_out (input, N, updated membrane) and nrn_flag_out (input, 1, result valid).
REQ-011 The block SHALL have output ports busy (1), done (1, one-cycle pulse), err (1, sticky timeout), spike_vec (NUM_NRN, spikes of last timestep) and spike_cnt (NUM_NRN*CNT_W, accumulated counts).

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, CAPTURE, GAP, DONE; busy SHALL be 1 in every state except IDLE.
REQ-013 In IDLE, start SHALL latch cur_in into the current registers, clear spike_vec, set idx=0 and go to ISSUE; start outside IDLE SHALL be ignored.
REQ-014 In ISSUE, nrn_flag_in SHALL be 1, nrn_vmem SHALL equal mem[idx] and nrn_in SHALL equal cur[idx]; the FSM SHALL go to CAPTURE.
REQ-015 In CAPTURE, nrn_flag_in SHALL stay 1; if nrn_flag_out=1, mem[idx] SHALL take nrn_mem_out, spike_vec[idx] SHALL take (nrn_out!=0), cnt[idx] SHALL increment on a spike, and the FSM SHALL go to GAP.
REQ-016 In CAPTURE with nrn_flag_out=0 for TIMEOUT consecutive cycles, err SHALL be set, mem[idx] SHALL be kept, spike_vec[idx] SHALL be 0 and the FSM SHALL go to GAP.
REQ-017 In GAP, nrn_flag_in SHALL be 0 for exactly one cycle; because the neuron's flag_out is sticky, this edge re-arms it. The FSM SHALL go to ISSUE with idx+1, or to DONE if idx=NUM_NRN-1.
REQ-018 DONE SHALL assert done for one cycle and return to IDLE; with no timeouts, done SHALL appear 3*NUM_NRN+1 cycles after the start cycle.
REQ-019 Spike counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 clr_mem SHALL act only in IDLE and be ignored otherwise; it SHALL zero all mem, cnt and err. With start in the same cycle, the clear SHALL apply first and the timestep SHALL use zeroed membranes.
REQ-021 Membranes SHALL be stored and forwarded unmodified as sign-magnitude words; the block SHALL do no arithmetic on them.

Reset
REQ-022 reset SHALL force IDLE with busy=0, done=0, err=0, nrn_flag_in=0, nrn_vmem=0, nrn_in=0, spike_vec=0, all mem/cnt/cur=0, on the next clock edge, including mid-timestep.
REQ-023 reset SHALL take priority over start and clr_mem.

Structure
REQ-024 A shared package nrn_pkg SHALL hold N, Q, the fixed-point word typedef, the constants ONE_Q (35'h1_0000_0000) and SIGN_BIT, and the scheduler state enum.
REQ-025 The saturating counter SHALL be one sub-module, spk_cnt, instantiated NUM_NRN times.

Verification
REQ-026 The bench SHALL cover reset: after reset, all outputs are 0; start with a stub never asserting flag_out -> nrn_flag_in=1 in ISSUE; reset in CAPTURE -> IDLE and nrn_flag_in=0 next cycle.
REQ-027 The bench SHALL cover positive currents: real nrn, NUM_NRN=4, all currents 35'h1_0000_0000, cleared membranes -> spike_vec=4'b1111, each mem=35'h1_0000_0000, each cnt=1, done at cycle 13.
REQ-028 The bench SHALL cover a negative current: cur[2]=35'h5_0000_0000, others positive 1.0 -> spike_vec=4'b1011, mem[2]=35'h5_0000_0000.
REQ-029 The bench SHALL cover timeout: stub withholds flag_out for neuron 1 -> err=1 after 16 CAPTURE cycles, spike_vec[1]=0, mem[1] unchanged, neurons 2-3 still processed, done asserted.
REQ-030 The bench SHALL cover saturation: 260 timesteps with a constant spike on neuron 0 -> cnt[0]=255.
REQ-031 The bench SHALL cover busy-time inputs: start and clr_mem pulsed while busy are ignored (no restart, values kept); clr_mem with start in IDLE -> run uses zero membranes.

Source files
------------

// File: rtl/nrn_pkg.sv
// Shared types and constants for the neuron scheduler: fixed-point word format
// and scheduler state encoding.
package nrn_pkg;
  localparam int N        = 35;
  localparam int Q        = 32;
  typedef logic [N-1:0] word_t;
  localparam word_t ONE_Q = 35'h1_0000_0000;
  localparam int SIGN_BIT = N - 1;

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, GAP, DONE} sched_st_e;
endpackage

// File: rtl/spk_cnt.sv
// Per-neuron spike counter; saturates at all-ones instead of wrapping.
module spk_cnt #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/nrn_sched.sv
// Time-multiplexes NUM_NRN neurons onto one external nrn instance: per timestep,
// each neuron is issued, its result captured (or timed out), then the flag re-armed.
module nrn_sched #(
  parameter int NUM_NRN = 4,
  parameter int N       = 35,
  parameter int Q       = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clr_mem,
  input  logic [NUM_NRN*N-1:0]     cur_in,
  output logic                     nrn_flag_in,
  output logic [N-1:0]             nrn_vmem,
  output logic [N-1:0]             nrn_in,
  input  logic [N-1:0]             nrn_out,
  input  logic [N-1:0]             nrn_mem_out,
  input  logic                     nrn_flag_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [NUM_NRN-1:0]       spike_vec,
  output logic [NUM_NRN*CNT_W-1:0] spike_cnt
);
  localparam int IDX_W = (NUM_NRN > 1) ? $clog2(NUM_NRN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  if (Q >= N || TIMEOUT < 1 || NUM_NRN < 1) begin : g_cfg_err
    $error("nrn_sched: invalid parameter combination");
  end

  nrn_pkg::sched_st_e          state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [TMO_W-1:0]            tmo_q;
  logic [NUM_NRN-1:0][N-1:0]   mem_q, cur_q;
  logic [NUM_NRN-1:0]          spk_q;
  logic                        fin_q, err_q, done_q;
  logic                        cap_ok, cnt_clr;
  logic [NUM_NRN-1:0]          inc;

  assign cap_ok  = (state_q == nrn_pkg::CAPTURE) && nrn_flag_out;
  assign cnt_clr = (state_q == nrn_pkg::IDLE) && clr_mem;

  for (genvar k = 0; k < NUM_NRN; k++) begin : g_cnt
    assign inc[k] = cap_ok && (idx_q == IDX_W'(k)) && (|nrn_out);
    spk_cnt #(.W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clr_i (cnt_clr),
      .inc_i (inc[k]),
      .cnt_o (spike_cnt[k*CNT_W +: CNT_W])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= nrn_pkg::IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      mem_q   <= '0;
      cur_q   <= '0;
      spk_q   <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        nrn_pkg::IDLE: begin
          // Clear lands on the same edge as a start, so the run sees zeroed membranes.
          if (clr_mem) begin
            mem_q <= '0;
            err_q <= 1'b0;
          end
          if (start) begin
            cur_q   <= cur_in;
            spk_q   <= '0;
            idx_q   <= '0;
            fin_q   <= 1'b1;
            state_q <= nrn_pkg::ISSUE;
          end
        end
        nrn_pkg::ISSUE: begin
          tmo_q   <= '0;
          state_q <= nrn_pkg::CAPTURE;
        end
        nrn_pkg::CAPTURE: begin
          if (nrn_flag_out) begin
            mem_q[idx_q] <= nrn_mem_out;
            spk_q[idx_q] <= |nrn_out;
            fin_q        <= 1'b0;
            state_q      <= nrn_pkg::GAP;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_q        <= 1'b1;
            spk_q[idx_q] <= 1'b0;
            fin_q        <= 1'b0;
            state_q      <= nrn_pkg::GAP;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        nrn_pkg::GAP: begin
          // One low cycle on flag_in drops the neuron's sticky flag_out.
          if (idx_q == IDX_W'(NUM_NRN - 1)) begin
            done_q  <= 1'b1;
            state_q <= nrn_pkg::DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            fin_q   <= 1'b1;
            state_q <= nrn_pkg::ISSUE;
          end
        end
        nrn_pkg::DONE: state_q <= nrn_pkg::IDLE;
        default:       state_q <= nrn_pkg::IDLE;
      endcase
    end
  end

  assign busy        = (state_q != nrn_pkg::IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign nrn_flag_in = fin_q;
  assign nrn_vmem    = mem_q[idx_q];
  assign nrn_in      = cur_q[idx_q];
  assign spike_vec   = spk_q;
endmodule

// File: tb/tb_nrn_sched.sv
// Bench for nrn_sched: behavioural neuron with stub modes, issue-time scoreboard
// on nrn_vmem/nrn_in, and per-timestep checks of done timing, spikes, counts, err.
module tb_nrn_sched;
  import nrn_pkg::*;

  localparam int NN = 4;
  localparam int W  = 35;
  localparam int CW = 8;

  logic            clock = 1'b0;
  logic            reset, start, clr_mem;
  logic [NN*W-1:0] cur_in;
  logic            nrn_flag_in, nrn_flag_out;
  logic [W-1:0]    nrn_vmem, nrn_in, nrn_out, nrn_mem_out;
  logic            busy, done, err;
  logic [NN-1:0]   spike_vec;
  logic [NN*CW-1:0] spike_cnt;

  int checks = 0;
  int errors = 0;

  nrn_sched #(.NUM_NRN(NN), .N(W), .Q(32), .TIMEOUT(16), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .clr_mem(clr_mem), .cur_in(cur_in),
    .nrn_flag_in(nrn_flag_in), .nrn_vmem(nrn_vmem), .nrn_in(nrn_in),
    .nrn_out(nrn_out), .nrn_mem_out(nrn_mem_out), .nrn_flag_out(nrn_flag_out),
    .busy(busy), .done(done), .err(err), .spike_vec(spike_vec), .spike_cnt(spike_cnt)
  );

  always #5 clock = ~clock;

  function automatic word_t sm_add(input word_t a, input word_t b);
    word_t r;
    if (a[W-1] == b[W-1])         r = {a[W-1], a[W-2:0] + b[W-2:0]};
    else if (a[W-2:0] >= b[W-2:0]) r = {a[W-1], a[W-2:0] - b[W-2:0]};
    else                           r = {b[W-1], b[W-2:0] - a[W-2:0]};
    if (r[W-2:0] == '0) r = '0;
    return r;
  endfunction

  // Behavioural neuron: integrates without leak or reset, spikes at >= +1.0,
  // flag_out sticky until flag_in drops.
  logic       hold_all = 1'b0, force_spk = 1'b0;
  logic [3:0] hold_mask = '0;
  int         eidx = -1;
  logic       m_prev = 1'b0;
  word_t      m_r;
  always @(posedge clock) begin
    if (nrn_flag_in && !m_prev) eidx = eidx + 1;
    m_prev = nrn_flag_in;
    if (reset || !nrn_flag_in) begin
      nrn_flag_out <= 1'b0;
    end else if (!nrn_flag_out && !hold_all && !hold_mask[eidx[1:0]]) begin
      nrn_flag_out <= 1'b1;
      if (force_spk) begin
        nrn_mem_out <= nrn_vmem;
        nrn_out     <= ONE_Q;
      end else begin
        m_r = sm_add(nrn_vmem, nrn_in);
        nrn_mem_out <= m_r;
        nrn_out     <= (!m_r[SIGN_BIT] && m_r[W-2:0] >= ONE_Q[W-2:0]) ? ONE_Q : '0;
      end
    end
  end

  // Scoreboard: one entry per neuron issue, compared on the first ISSUE cycle.
  typedef struct { word_t vmem; word_t cur; } exp_t;
  exp_t exp_q[$];
  logic sb_en = 1'b0;
  logic mon_prev = 1'b0;
  always @(negedge clock) begin
    if (sb_en && nrn_flag_in && !mon_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_issue: unexpected issue, vmem=%h in=%h", nrn_vmem, nrn_in);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (nrn_vmem !== e.vmem || nrn_in !== e.cur) begin
          errors++;
          $display("FAIL sb_issue: got vmem=%h in=%h, want vmem=%h in=%h",
                   nrn_vmem, nrn_in, e.vmem, e.cur);
        end
      end
    end
    mon_prev = nrn_flag_in;
  end

  word_t bm_mem[NN];
  int    bm_cnt[NN];
  logic  bm_err;

  function automatic logic [NN*W-1:0] all_cur(input word_t v);
    logic [NN*W-1:0] r;
    for (int k = 0; k < NN; k++) r[k*W +: W] = v;
    return r;
  endfunction

  task automatic run_step(input logic [NN*W-1:0] cur, input logic [3:0] hold,
                          input logic [3:0] exp_spk, input int exp_cyc,
                          input logic do_clr, input logic noise);
    int cyc;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clock);
    if (do_clr) begin
      for (int k = 0; k < NN; k++) begin bm_mem[k] = '0; bm_cnt[k] = 0; end
      bm_err = 1'b0;
    end
    for (int k = 0; k < NN; k++) begin
      exp_q.push_back('{bm_mem[k], cur[k*W +: W]});
      if (hold[k]) bm_err = 1'b1;
      else if (!force_spk) bm_mem[k] = sm_add(bm_mem[k], cur[k*W +: W]);
      if (exp_spk[k] && bm_cnt[k] < 255) bm_cnt[k]++;
    end
    hold_mask = hold;
    eidx = -1;
    @(negedge clock);
    cur_in = cur; start = 1'b1; clr_mem = do_clr;
    @(posedge clock); #1;
    start = 1'b0; clr_mem = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      if (noise) begin
        if (cyc == 4 || cyc == 12) begin start = 1'b1; clr_mem = 1'b1; cur_in = '1; end
        else begin start = 1'b0; clr_mem = 1'b0; end
      end
      if (done === 1'b1) break;
      @(posedge clock); #1; cyc++;
    end
    start = 1'b0; clr_mem = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_seen: done=%b after %0d cycles, want 1", done, cyc);
    end
    if (exp_cyc > 0) begin
      checks++;
      if (cyc != exp_cyc) begin
        errors++; $display("FAIL done_cycle: got cycle %0d, want %0d", cyc, exp_cyc);
      end
    end
    checks++;
    if (spike_vec !== exp_spk) begin
      errors++; $display("FAIL spike_vec: got %b, want %b", spike_vec, exp_spk);
    end
    checks++;
    if (err !== bm_err) begin
      errors++; $display("FAIL err: got %b, want %b", err, bm_err);
    end
    for (int k = 0; k < NN; k++) begin
      checks++;
      if (spike_cnt[k*CW +: CW] !== CW'(bm_cnt[k])) begin
        errors++;
        $display("FAIL cnt%0d: got %0d, want %0d", k, spike_cnt[k*CW +: CW], bm_cnt[k]);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d issues missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; clr_mem = 1'b0; cur_in = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, err, nrn_flag_in} !== 4'b0 || nrn_vmem !== '0 || nrn_in !== '0 ||
        spike_vec !== '0 || spike_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b err=%b fin=%b vmem=%h in=%h spk=%b cnt=%h, want all 0",
               busy, done, err, nrn_flag_in, nrn_vmem, nrn_in, spike_vec, spike_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
    hold_all = 1'b1;
    cur_in = all_cur(35'h0_8000_0000);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (nrn_flag_in !== 1'b1 || busy !== 1'b1 || nrn_in !== 35'h0_8000_0000) begin
      errors++;
      $display("FAIL issue_flag: fin=%b busy=%b in=%h, want 1 1 080000000", nrn_flag_in, busy, nrn_in);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (nrn_flag_in !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL capture_wait: fin=%b err=%b, want 1 0", nrn_flag_in, err);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || nrn_flag_in !== 1'b0 || nrn_in !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b fin=%b in=%h err=%b, want 0 0 0 0", busy, nrn_flag_in, nrn_in, err);
    end
    @(negedge clock); reset = 1'b0; hold_all = 1'b0;
    for (int k = 0; k < NN; k++) begin bm_mem[k] = '0; bm_cnt[k] = 0; end
    bm_err = 1'b0;
  endtask

  task automatic test_positive;
    run_step(all_cur(ONE_Q), 4'b0000, 4'b1111, 13, 1'b1, 1'b0);
    for (int k = 0; k < NN; k++) begin
      checks++;
      if (spike_cnt[k*CW +: CW] !== 8'd1) begin
        errors++; $display("FAIL pos_cnt%0d: got %0d, want 1", k, spike_cnt[k*CW +: CW]);
      end
    end
    run_step(all_cur(ONE_Q), 4'b0000, 4'b1111, 13, 1'b0, 1'b0);
  endtask

  task automatic test_negative;
    logic [NN*W-1:0] c;
    c = all_cur(ONE_Q);
    c[2*W +: W] = 35'h5_0000_0000;
    run_step(c, 4'b0000, 4'b1011, 13, 1'b1, 1'b0);
    checks++;
    if (bm_mem[2] !== 35'h5_0000_0000) begin
      errors++; $display("FAIL neg_model: got %h, want 500000000", bm_mem[2]);
    end
    run_step(all_cur('0), 4'b0000, 4'b1011, 13, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    run_step(all_cur(ONE_Q), 4'b0010, 4'b1101, 28, 1'b1, 1'b0);
    run_step(all_cur('0), 4'b0000, 4'b1101, 13, 1'b0, 1'b0);
  endtask

  task automatic test_busy_inputs;
    run_step(all_cur(ONE_Q), 4'b0000, 4'b1111, 13, 1'b0, 1'b1);
    run_step(all_cur(ONE_Q), 4'b0000, 4'b1111, 13, 1'b1, 1'b0);
  endtask

  task automatic test_saturation;
    force_spk = 1'b1;
    run_step(all_cur('0), 4'b0000, 4'b1111, 13, 1'b1, 1'b0);
    for (int s = 1; s < 260; s++) run_step(all_cur('0), 4'b0000, 4'b1111, 13, 1'b0, 1'b0);
    force_spk = 1'b0;
    checks++;
    if (spike_cnt[0 +: CW] !== 8'd255) begin
      errors++; $display("FAIL sat_cnt0: got %0d, want 255", spike_cnt[0 +: CW]);
    end
  endtask

  initial begin
    test_reset;
    sb_en = 1'b1;
    test_positive;
    test_negative;
    test_timeout;
    test_busy_inputs;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
